// File: rtl/imem_refill_responder.sv
// rtl/imem_refill_responder.sv - instruction-cache line refill responder with internal instruction store
//
// Accepts one line-fill request, waits LATENCY cycles, then returns the
// 4-word line critical word first over a valid/ready beat stream.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   req_valid/ready   line-fill request handshake (ready only while idle)
//   req_addr          byte address of the missed word; [3:2] pick the critical word
//   resp_valid/ready  beat handshake
//   resp_data         instruction word of the current beat
//   resp_word_idx     word offset of the current beat within its line
//   resp_last         marks the fourth beat of the line
//   resp_err          request fell outside the instruction store
//   load_we/addr/data preload write port into the instruction store
//   refill_count      completed line refills, wraps
module imem_refill_responder #(
    parameter int               LATENCY            = 3,
    parameter int               XLEN               = 32,
    parameter int               MEM_WORDS          = 1024,
    parameter int               WORD_ADDR_WIDTH    = $clog2(MEM_WORDS),
    parameter int               PERF_COUNTER_WIDTH = 32,
    parameter logic [XLEN-1:0]  NOP_INSTR          = 'h13
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [XLEN-1:0]               req_addr,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [XLEN-1:0]               resp_data,
    output logic [1:0]                    resp_word_idx,
    output logic                          resp_last,
    output logic                          resp_err,
    input  logic                          load_we,
    input  logic [WORD_ADDR_WIDTH-1:0]    load_addr,
    input  logic [XLEN-1:0]               load_data,
    output logic [PERF_COUNTER_WIDTH-1:0] refill_count
);

    localparam int         BASE_W = WORD_ADDR_WIDTH - 2;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t state, state_next;

    logic [XLEN-1:0]            mem [0:MEM_WORDS-1];

    logic [BASE_W-1:0]          line_base;
    logic [1:0]                 start_idx;
    logic                       line_err;
    logic [3:0]                 wait_cnt;
    logic [1:0]                 beat;

    logic                       accept;
    logic                       capture_first;
    logic                       advance;
    logic                       line_done;
    logic [1:0]                 next_idx;
    logic [1:0]                 next_beat;
    logic [WORD_ADDR_WIDTH-1:0] rd_addr;

    // Byte offset bits within a word carry no information for a word store.
    logic                       unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        accept        = 1'b0;
        capture_first = 1'b0;
        advance       = 1'b0;
        line_done     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                if (req_valid) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    capture_first = 1'b1;
                    state_next    = BURST;
                end
            end
            BURST: begin
                if (resp_valid && resp_ready) begin
                    if (resp_last) begin
                        line_done  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat n of the line reads word (start + n) mod 4, wrapping inside the line.
    assign next_idx  = capture_first ? start_idx : resp_word_idx + 2'd1;
    assign next_beat = capture_first ? 2'd0 : beat + 2'd1;
    assign rd_addr   = {line_base, next_idx};

    // Store writes are accepted in every state; the beat capture below reads
    // the pre-edge contents, so a same-edge write returns the old word.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_word_idx <= 2'd0;
            resp_last     <= 1'b0;
            resp_err      <= 1'b0;
            refill_count  <= '0;
            line_base     <= '0;
            start_idx     <= 2'd0;
            line_err      <= 1'b0;
            wait_cnt      <= 4'd0;
            beat          <= 2'd0;
        end else begin
            if (accept) begin
                line_base <= req_addr[WORD_ADDR_WIDTH+1:4];
                start_idx <= req_addr[3:2];
                line_err  <= (req_addr[XLEN-1:WORD_ADDR_WIDTH+2] != '0);
                wait_cnt  <= LAT_M1;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (capture_first || advance) begin
                resp_valid    <= 1'b1;
                resp_word_idx <= next_idx;
                resp_data     <= line_err ? NOP_INSTR : mem[rd_addr];
                resp_err      <= line_err;
                resp_last     <= (next_beat == 2'd3);
                beat          <= next_beat;
            end else if (line_done) begin
                resp_valid   <= 1'b0;
                resp_last    <= 1'b0;
                refill_count <= refill_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_refill_responder.sv
// tb/tb_imem_refill_responder.sv - directed self-checking bench for imem_refill_responder
module tb_imem_refill_responder;

    localparam int LAT = 3;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp_word_idx;
    logic        resp_last;
    logic        resp_err;
    logic        load_we;
    logic [9:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] refill_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_count = 0;

    localparam logic [31:0] A0 = 32'hA0A0_0040;
    localparam logic [31:0] A1 = 32'hA1A1_0041;
    localparam logic [31:0] A2 = 32'hA2A2_0042;
    localparam logic [31:0] A3 = 32'hA3A3_0043;
    localparam logic [31:0] B1 = 32'hB1B1_0041;
    localparam logic [31:0] NOP = 32'h0000_0013;

    imem_refill_responder #(.LATENCY(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_word_idx (resp_word_idx),
        .resp_last     (resp_last),
        .resp_err      (resp_err),
        .load_we       (load_we),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .refill_count  (refill_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        load_we = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_we = 1'b0;
    endtask

    task automatic issue_req(input logic [31:0] addr);
        @(posedge clk); #1;
        check("req_ready_before", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_addr = addr;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Runs one full line. d0..d3 are the expected words by line offset.
    // stall_beat/stall_len hold resp_ready low while that beat is presented;
    // wr_beat drives a store write on the edge that captures that beat.
    task automatic run_line(input logic [31:0] addr,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3,
                            input logic e,
                            input int stall_beat, input int stall_len,
                            input int wr_beat, input logic [9:0] wr_addr,
                            input logic [31:0] wr_data);
        logic [31:0] words [4];
        logic [1:0]  idx;
        words[0] = d0; words[1] = d1; words[2] = d2; words[3] = d3;
        resp_ready = 1'b1;
        issue_req(addr);
        for (int i = 0; i < LAT; i++) begin
            check("latency_valid_low", {63'd0, resp_valid}, 64'd0);
            check("latency_req_ready_low", {63'd0, req_ready}, 64'd0);
            @(posedge clk); #1;
        end
        for (int b = 0; b < 4; b++) begin
            idx = addr[3:2] + 2'(b);
            if (b == stall_beat) begin
                resp_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check("stall_valid", {63'd0, resp_valid}, 64'd1);
                    check("stall_idx", {62'd0, resp_word_idx}, {62'd0, idx});
                    check("stall_data", {32'd0, resp_data}, {32'd0, e ? NOP : words[idx]});
                    check("stall_req_ready", {63'd0, req_ready}, 64'd0);
                    @(posedge clk); #1;
                end
                resp_ready = 1'b1;
            end
            check("beat_valid", {63'd0, resp_valid}, 64'd1);
            check("beat_idx", {62'd0, resp_word_idx}, {62'd0, idx});
            check("beat_data", {32'd0, resp_data}, {32'd0, e ? NOP : words[idx]});
            check("beat_last", {63'd0, resp_last}, {63'd0, (b == 3)});
            check("beat_err", {63'd0, resp_err}, {63'd0, e});
            if (wr_beat == b + 1) begin
                load_we = 1'b1; load_addr = wr_addr; load_data = wr_data;
            end
            @(posedge clk); #1;
            load_we = 1'b0;
        end
        exp_count++;
        check("done_valid_low", {63'd0, resp_valid}, 64'd0);
        check("done_req_ready", {63'd0, req_ready}, 64'd1);
        check("refill_count", {32'd0, refill_count}, 64'(exp_count));
    endtask

    task automatic check_idle_after_reset();
        check("rst_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_count", {32'd0, refill_count}, 64'd0);
        for (int i = 0; i < LAT + 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_beat", {63'd0, resp_valid}, 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
        load_we = 1'b0; load_addr = '0; load_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", {63'd0, req_ready}, 64'd1);
        check("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("reset_resp_last", {63'd0, resp_last}, 64'd0);
        check("reset_resp_err", {63'd0, resp_err}, 64'd0);
        check("reset_resp_data", {32'd0, resp_data}, 64'd0);
        check("reset_word_idx", {62'd0, resp_word_idx}, 64'd0);
        check("reset_refill_count", {32'd0, refill_count}, 64'd0);
        rst = 1'b0;

        preload(10'h040, A0);
        preload(10'h041, A1);
        preload(10'h042, A2);
        preload(10'h043, A3);

        run_line(32'h0000_0100, A0, A1, A2, A3, 1'b0, -1, 0, -1, '0, '0);
        run_line(32'h0000_0108, A0, A1, A2, A3, 1'b0, -1, 0, -1, '0, '0);
        run_line(32'h0000_0104, A0, A1, A2, A3, 1'b0, 1, 5, -1, '0, '0);
        run_line(32'h0000_2000, A0, A1, A2, A3, 1'b1, -1, 0, -1, '0, '0);
        run_line(32'h0000_0100, A0, A1, A2, A3, 1'b0, -1, 0, 1, 10'h041, B1);
        run_line(32'h0000_0101, A0, B1, A2, A3, 1'b0, -1, 0, -1, '0, '0);

        // Reset while waiting out the access latency.
        issue_req(32'h0000_0100);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_count = 0;
        check_idle_after_reset();
        run_line(32'h0000_010C, A0, B1, A2, A3, 1'b0, -1, 0, -1, '0, '0);

        // Reset after the first beat of a burst has been taken.
        resp_ready = 1'b1;
        issue_req(32'h0000_0100);
        repeat (LAT) @(posedge clk);
        #1;
        check("burst_beat0_valid", {63'd0, resp_valid}, 64'd1);
        @(posedge clk); #1;
        check("burst_beat1_idx", {62'd0, resp_word_idx}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_count = 0;
        check_idle_after_reset();
        run_line(32'h0000_0108, A0, B1, A2, A3, 1'b0, 2, 2, -1, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
